// File: rtl/dac_sample_tx_if.sv
// Sample-pair handshake plus DAC write bus for dac_sample_tx.
// The block (slave) owns o_*; upstream logic and the DAC side (master) own i_*.
interface dac_sample_tx_if #(
    parameter int DAC_CHDATA_SIZE = 16,
    parameter int DAC_DATA_SIZE   = 14,
    parameter int DAC_CALIB_SIZE  = 18
);
    logic                              i_enable;
    logic                              i_valid;
    logic                              o_ready;
    logic signed [DAC_CHDATA_SIZE-1:0] i_data_ch1;
    logic signed [DAC_CHDATA_SIZE-1:0] i_data_ch2;
    logic signed [DAC_CALIB_SIZE-1:0]  i_mult_coef;
    logic signed [DAC_CALIB_SIZE-1:0]  i_add_coef;
    logic        [DAC_DATA_SIZE-1:0]   o_dac_data;
    logic                              o_dac_sel;
    logic                              o_dac_wr;
    logic                              o_dac_rst;
    logic                              o_sat;
    logic                              o_init_done;

    modport slave (
        input  i_enable, i_valid, i_data_ch1, i_data_ch2, i_mult_coef, i_add_coef,
        output o_ready, o_dac_data, o_dac_sel, o_dac_wr, o_dac_rst, o_sat, o_init_done
    );

    modport master (
        output i_enable, i_valid, i_data_ch1, i_data_ch2, i_mult_coef, i_add_coef,
        input  o_ready, o_dac_data, o_dac_sel, o_dac_wr, o_dac_rst, o_sat, o_init_done
    );
endinterface

// File: rtl/dac_sample_tx.sv
// Calibrates a two-channel sample pair (gain, offset, saturation) and writes
// both words to a shared-bus DAC, after holding the DAC in reset and letting it settle.
module dac_sample_tx #(
    parameter int DAC_CHDATA_SIZE  = 16,
    parameter int DAC_DATA_SIZE    = 14,
    parameter int DAC_CALIB_SIZE   = 18,
    parameter int INIT_WAIT_CYCLES = 1000
) (
    input  logic           i_sys_clock,
    input  logic           i_reset,
    dac_sample_tx_if.slave bus,
    output logic [2:0]     dbg_state
);
    localparam int RST_HOLD_CYCLES = 16;
    localparam int FRAC_BITS       = 16;
    localparam int PROD_W          = DAC_CHDATA_SIZE + DAC_CALIB_SIZE;
    localparam int SUM_W           = DAC_CALIB_SIZE + 1;
    localparam int R_W             = SUM_W - 2;
    localparam int CNT_MAX         = (INIT_WAIT_CYCLES > RST_HOLD_CYCLES) ? INIT_WAIT_CYCLES : RST_HOLD_CYCLES;
    localparam int CNT_W           = $clog2(CNT_MAX) + 1;
    localparam int DAC_MAX_I       = (1 << (DAC_DATA_SIZE - 1)) - 1;
    localparam logic signed [R_W-1:0] DAC_MAX = R_W'(DAC_MAX_I);
    localparam logic signed [R_W-1:0] DAC_MIN = R_W'(-DAC_MAX_I - 1);

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        INIT_WAIT = 3'd1,
        IDLE      = 3'd2,
        CALC      = 3'd3,
        OUT1      = 3'd4,
        OUT2      = 3'd5
    } state_t;

    state_t                      state, state_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic                        accept;
    logic signed [DAC_CHDATA_SIZE-1:0] ch1_q, ch2_q;
    logic signed [DAC_CALIB_SIZE-1:0]  mult_q, add_q;
    logic signed [PROD_W-1:0]    p1, p2;
    logic signed [SUM_W-1:0]     c1, c2;
    logic signed [R_W-1:0]       r1, r2;
    logic [DAC_DATA_SIZE:0]      w1, w2;
    logic [DAC_DATA_SIZE-1:0]    dac_q, res2_q;
    logic                        sat1_q, sat2_q;

    // Clip to the DAC range; MSB of the result flags that clipping happened.
    function automatic logic [DAC_DATA_SIZE:0] sat_word(input logic signed [R_W-1:0] r);
        if (r > DAC_MAX)
            return {1'b1, DAC_MAX[DAC_DATA_SIZE-1:0]};
        else if (r < DAC_MIN)
            return {1'b1, DAC_MIN[DAC_DATA_SIZE-1:0]};
        else
            return {1'b0, r[DAC_DATA_SIZE-1:0]};
    endfunction

    // Handshake: a pair transfers on a rising edge where i_valid && o_ready;
    // o_ready depends only on state and i_enable, never on i_valid.
    assign accept    = (state == IDLE) && bus.i_enable && bus.i_valid;
    assign dbg_state = state;

    always_ff @(posedge i_sys_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= RST_HOLD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        bus.o_ready     = 1'b0;
        bus.o_dac_wr    = 1'b0;
        bus.o_dac_sel   = 1'b0;
        bus.o_dac_rst   = 1'b0;
        bus.o_sat       = 1'b0;
        bus.o_init_done = 1'b1;
        case (state)
            RST_HOLD: begin
                bus.o_dac_rst   = 1'b1;
                bus.o_init_done = 1'b0;
                if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_nxt = INIT_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            INIT_WAIT: begin
                bus.o_init_done = 1'b0;
                if (cnt == CNT_W'(INIT_WAIT_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                bus.o_ready = bus.i_enable;
                if (accept) state_nxt = CALC;
            end
            CALC: state_nxt = OUT1;
            OUT1: begin
                bus.o_dac_wr = 1'b1;
                bus.o_sat    = sat1_q;
                state_nxt    = OUT2;
            end
            OUT2: begin
                bus.o_dac_wr  = 1'b1;
                bus.o_dac_sel = 1'b1;
                bus.o_sat     = sat2_q;
                state_nxt     = IDLE;
            end
            default: begin
                bus.o_init_done = 1'b0;
                state_nxt       = RST_HOLD;
                cnt_nxt         = '0;
            end
        endcase
    end

    // Q2.16 gain, offset in input LSBs, then drop two LSBs to reach DAC width.
    always_comb begin
        p1 = PROD_W'(ch1_q) * PROD_W'(mult_q);
        p2 = PROD_W'(ch2_q) * PROD_W'(mult_q);
        c1 = SUM_W'(p1 >>> FRAC_BITS) + SUM_W'(add_q);
        c2 = SUM_W'(p2 >>> FRAC_BITS) + SUM_W'(add_q);
        r1 = R_W'(c1 >>> 2);
        r2 = R_W'(c2 >>> 2);
        w1 = sat_word(r1);
        w2 = sat_word(r2);
    end

    always_ff @(posedge i_sys_clock or negedge i_reset) begin
        if (!i_reset) begin
            ch1_q  <= '0;
            ch2_q  <= '0;
            mult_q <= '0;
            add_q  <= '0;
            dac_q  <= '0;
            res2_q <= '0;
            sat1_q <= 1'b0;
            sat2_q <= 1'b0;
        end else begin
            if (accept) begin
                ch1_q  <= bus.i_data_ch1;
                ch2_q  <= bus.i_data_ch2;
                mult_q <= bus.i_mult_coef;
                add_q  <= bus.i_add_coef;
            end
            if (state == CALC) begin
                dac_q  <= w1[DAC_DATA_SIZE-1:0];
                sat1_q <= w1[DAC_DATA_SIZE];
                res2_q <= w2[DAC_DATA_SIZE-1:0];
                sat2_q <= w2[DAC_DATA_SIZE];
            end
            // dac_q keeps the ch2 word after OUT2 so the bus holds between writes.
            if (state == OUT1) dac_q <= res2_q;
        end
    end

    assign bus.o_dac_data = dac_q;
endmodule
